// File: rtl/cache_pkg.sv
// ============================================================================
// cache_pkg : shared types, widths and address helpers for wb_cache_ctrl
// Revision  : 1.0
// ============================================================================
`default_nettype none

package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;
  localparam int WORD_W   = 32;

  // Results are 32 bits wide; callers truncate to their own IDX_W / TAG_W.
  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int idx_w);
    return (addr >> OFFSET_W) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int idx_w);
    return addr >> (OFFSET_W + idx_w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/line_word_merge.sv
// ============================================================================
// line_word_merge : byte-masked insertion of one 32-bit word into a 256-bit line
// Revision        : 1.0
// ============================================================================
`default_nettype none

module line_word_merge
  import cache_pkg::*;
(
  input  logic [LINE_W-1:0] old_line,
  input  logic [WORD_W-1:0] word,
  input  logic [2:0]        offset,   // word slot within the line (byte offset [4:2])
  input  logic [3:0]        wmask,
  output logic [LINE_W-1:0] new_line
);

  logic [LINE_W/8-1:0] w_be;

  assign w_be = {28'd0, wmask} << {offset, 2'b00};

  for (genvar i = 0; i < LINE_W/8; i++) begin : g_byte
    assign new_line[8*i +: 8] = w_be[i] ? word[8*(i%4) +: 8] : old_line[8*i +: 8];
  end

endmodule

`default_nettype wire

// File: rtl/wb_cache_ctrl.sv
// ============================================================================
// wb_cache_ctrl : direct-mapped write-back / write-allocate cache controller
// Revision      : 1.0
// ============================================================================
`default_nettype none

module wb_cache_ctrl
  import cache_pkg::*;
#(
  parameter int SETS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ufp_addr,
  input  logic [3:0]        ufp_rmask,
  input  logic [3:0]        ufp_wmask,
  input  logic [31:0]       ufp_wdata,
  output logic [31:0]       ufp_rdata,
  output logic              ufp_resp,
  output logic [31:0]       dfp_addr,
  output logic              dfp_read,
  output logic              dfp_write,
  output logic [LINE_W-1:0] dfp_wdata,
  input  logic [LINE_W-1:0] dfp_rdata,
  input  logic              dfp_resp
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 27 - IDX_W;

  state_t            r_state;
  logic [31:0]       r_addr;
  logic [3:0]        r_wmask;
  logic [31:0]       r_wdata;
  logic [SETS-1:0]   r_valid;
  logic [SETS-1:0]   r_dirty;
  logic [LINE_W-1:0] r_data [SETS];
  logic [TAG_W-1:0]  r_tag  [SETS];

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [LINE_W-1:0] w_line;
  logic [LINE_W-1:0] w_merged;
  logic [WORD_W-1:0] w_rword;
  logic              w_hit;
  logic              w_is_write;
  logic              w_fill;
  logic              w_wr_hit;

  assign w_idx      = IDX_W'(addr_index(r_addr, IDX_W));
  assign w_tag      = TAG_W'(addr_tag(r_addr, IDX_W));
  assign w_line     = r_data[w_idx];
  assign w_rword    = w_line[{r_addr[4:2], 5'b0} +: WORD_W];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_is_write = |r_wmask;
  assign w_fill     = (r_state == ALLOCATE) && dfp_resp;
  assign w_wr_hit   = (r_state == COMPARE) && w_hit && w_is_write;

  line_word_merge u_merge (
    .old_line (w_line),
    .word     (r_wdata),
    .offset   (r_addr[4:2]),
    .wmask    (r_wmask),
    .new_line (w_merged)
  );

  // Line data and tags carry no reset; validity alone decides whether they matter.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_idx] <= dfp_rdata;
      r_tag[w_idx]  <= w_tag;
    end else if (w_wr_hit) begin
      r_data[w_idx] <= w_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wmask   <= '0;
      r_wdata   <= '0;
      r_valid   <= '0;
      r_dirty   <= '0;
      ufp_resp  <= 1'b0;
      ufp_rdata <= '0;
      dfp_read  <= 1'b0;
      dfp_write <= 1'b0;
      dfp_addr  <= '0;
      dfp_wdata <= '0;
    end else begin
      ufp_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          // The requester still holds the finished request during the resp cycle.
          if (!ufp_resp && ((|ufp_rmask) || (|ufp_wmask))) begin
            r_addr  <= ufp_addr;
            r_wmask <= ufp_wmask;
            r_wdata <= ufp_wdata;
            r_state <= COMPARE;
          end
        end
        COMPARE: begin
          if (w_hit) begin
            ufp_resp  <= 1'b1;
            ufp_rdata <= w_is_write ? '0 : w_rword;
            if (w_is_write) r_dirty[w_idx] <= 1'b1;
            r_state <= IDLE;
          end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
            dfp_write <= 1'b1;
            dfp_addr  <= {r_tag[w_idx], w_idx, 5'b0};
            dfp_wdata <= w_line;
            r_state   <= WRITEBACK;
          end else begin
            dfp_read <= 1'b1;
            dfp_addr <= {w_tag, w_idx, 5'b0};
            r_state  <= ALLOCATE;
          end
        end
        WRITEBACK: begin
          if (dfp_resp) begin
            dfp_write <= 1'b0;
            dfp_read  <= 1'b1;
            dfp_addr  <= {w_tag, w_idx, 5'b0};
            r_state   <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (dfp_resp) begin
            dfp_read       <= 1'b0;
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
            r_state        <= COMPARE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_cache_ctrl.sv
// ============================================================================
// tb_wb_cache_ctrl : scoreboard bench for wb_cache_ctrl against a flat memory model
// Revision         : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wb_cache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  ufp_addr;
  logic [3:0]   ufp_rmask;
  logic [3:0]   ufp_wmask;
  logic [31:0]  ufp_wdata;
  logic [31:0]  ufp_rdata;
  logic         ufp_resp;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;

  always #5 clk = ~clk;

  wb_cache_ctrl #(.SETS(16)) dut (
    .clk(clk), .rst(rst),
    .ufp_addr(ufp_addr), .ufp_rmask(ufp_rmask), .ufp_wmask(ufp_wmask), .ufp_wdata(ufp_wdata),
    .ufp_rdata(ufp_rdata), .ufp_resp(ufp_resp),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write), .dfp_wdata(dfp_wdata),
    .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0]  exp_q[$];
  logic [31:0]  ref_words [logic [31:0]];
  logic [255:0] mem_lines [logic [31:0]];
  logic [31:0]  rd_log[$];
  logic [31:0]  wr_log[$];
  logic [255:0] wr_data_log[$];
  bit           hold_dfp = 1'b0;
  bit           overlap  = 1'b0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    if (mem_lines.exists(la)) return mem_lines[la];
    for (int w = 0; w < 8; w++) l[32*w +: 32] = init_word(la + 32'(w * 4));
    return l;
  endfunction

  // Upstream view of memory: latest written word, else what downstream holds.
  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0]  wa;
    logic [255:0] l;
    wa = {a[31:2], 2'b00};
    if (ref_words.exists(wa)) return ref_words[wa];
    l = mem_line({wa[31:5], 5'b0});
    return l[32*wa[4:2] +: 32];
  endfunction

  function automatic logic [255:0] ref_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = ref_word(la + 32'(w * 4));
    return l;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check256(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: every completion pops exactly one expectation.
  always @(negedge clk) begin
    if (dfp_read && dfp_write) overlap = 1'b1;
    if (!rst && ufp_resp) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp rdata=%h, required no resp", ufp_rdata);
      end else begin
        check32("ufp_rdata", ufp_rdata, exp_q.pop_front());
      end
    end
  end

  // Downstream memory with random 0..5 cycle response delay.
  initial begin : responder
    logic [31:0] a;
    bit          w;
    dfp_resp  = 1'b0;
    dfp_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && !hold_dfp && (dfp_read || dfp_write)) begin
        a = dfp_addr;
        w = dfp_write;
        if (w) begin
          wr_log.push_back(a);
          wr_data_log.push_back(dfp_wdata);
          check256("victim_line", dfp_wdata, ref_line(a));
          mem_lines[a] = dfp_wdata;
        end else begin
          rd_log.push_back(a);
        end
        repeat ($urandom_range(0, 5)) @(negedge clk);
        dfp_rdata = w ? '0 : mem_line(a);
        dfp_resp  = 1'b1;
        @(negedge clk);
        dfp_resp  = 1'b0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 with the request dropped.
  task automatic req(input logic [31:0] a, input bit wr, input logic [3:0] m,
                     input logic [31:0] d, output int lat);
    logic [31:0] old;
    ufp_addr  = a;
    ufp_wdata = d;
    if (wr) begin
      ufp_rmask = 4'h0;
      ufp_wmask = m;
      old = ref_word(a);
      for (int b = 0; b < 4; b++) if (m[b]) old[8*b +: 8] = d[8*b +: 8];
      ref_words[{a[31:2], 2'b00}] = old;
      exp_q.push_back(32'h0);
    end else begin
      ufp_rmask = 4'hF;
      ufp_wmask = 4'h0;
      exp_q.push_back(ref_word(a));
    end
    lat = 0;
    forever begin
      @(negedge clk);
      if (ufp_resp) break;
      lat++;
      if (lat > 300) begin
        checks++;
        errors++;
        $display("FAIL resp_timeout: got no resp after %0d cycles, required resp for addr %h", lat, a);
        exp_q.delete();
        break;
      end
    end
    @(posedge clk);
    #1;
    ufp_rmask = 4'h0;
    ufp_wmask = 4'h0;
  endtask

  initial begin : stimulus
    int          lat;
    int          nact;
    int          wait_n;
    logic [31:0] a;
    logic [255:0] l;
    rst = 1'b1;
    ufp_addr = '0; ufp_rmask = '0; ufp_wmask = '0; ufp_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check32("rst_ufp_resp", 32'(ufp_resp), 32'd0);
    check32("rst_ufp_rdata", ufp_rdata, 32'd0);
    check32("rst_dfp_read", 32'(dfp_read), 32'd0);
    check32("rst_dfp_write", 32'(dfp_write), 32'd0);
    check32("rst_dfp_addr", dfp_addr, 32'd0);
    check256("rst_dfp_wdata", dfp_wdata, 256'd0);
    @(posedge clk); #1;

    // 1: fill line 0x40 carrying 0xDEADBEEF in word1, then hit on 0x44
    l = mem_line(32'h40);
    l[63:32] = 32'hDEADBEEF;
    mem_lines[32'h40] = l;
    req(32'h40, 1'b0, 4'h0, 32'h0, lat);
    check32("t1_fill_addr", (rd_log.size() > 0) ? rd_log[rd_log.size()-1] : 32'hFFFFFFFF, 32'h40);
    req(32'h44, 1'b0, 4'h0, 32'h0, lat);
    check32("t1_hit_latency", 32'(lat), 32'd2);

    // 2: partial write hit, no downstream traffic, then read back
    nact = rd_log.size() + wr_log.size();
    req(32'h44, 1'b1, 4'b0101, 32'h11223344, lat);
    check32("t2_write_latency", 32'(lat), 32'd2);
    req(32'h44, 1'b0, 4'h0, 32'h0, lat);
    check32("t2_no_dfp", 32'(rd_log.size() + wr_log.size()), 32'(nact));

    // 3: conflicting tag evicts the dirty line before refilling
    req(32'h240, 1'b0, 4'h0, 32'h0, lat);
    check32("t3_wb_addr", (wr_log.size() > 0) ? wr_log[wr_log.size()-1] : 32'hFFFFFFFF, 32'h40);
    l = (wr_data_log.size() > 0) ? wr_data_log[wr_data_log.size()-1] : '0;
    check32("t3_wb_word1", l[63:32], 32'hDE22BE44);
    check32("t3_fill_addr", (rd_log.size() > 0) ? rd_log[rd_log.size()-1] : 32'hFFFFFFFF, 32'h240);

    // 4: write miss into an invalid set, later evicted for a full-line check
    req(32'h1C, 1'b1, 4'hF, $urandom, lat);
    req(32'h21C, 1'b0, 4'h0, 32'h0, lat);
    check32("t4_wb_addr", (wr_log.size() > 0) ? wr_log[wr_log.size()-1] : 32'hFFFFFFFF, 32'h0);

    // 5: reset while ALLOCATE is waiting for memory
    req(32'h40, 1'b0, 4'h0, 32'h0, lat);
    hold_dfp  = 1'b1;
    ufp_addr  = 32'h640;
    ufp_rmask = 4'hF;
    wait_n = 0;
    while (!dfp_read && wait_n < 50) begin @(negedge clk); wait_n++; end
    check32("t5_alloc_seen", 32'(dfp_read), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    ufp_rmask = 4'h0;
    @(posedge clk);
    @(negedge clk);
    check32("t5_rst_dfp_read", 32'(dfp_read), 32'd0);
    check32("t5_rst_ufp_resp", 32'(ufp_resp), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    hold_dfp = 1'b0;
    ref_words.delete();
    nact = rd_log.size();
    req(32'h40, 1'b0, 4'h0, 32'h0, lat);
    check32("t5_miss_after_rst", 32'(rd_log.size()), 32'(nact + 1));

    // 6: random traffic confined to sets 0 and 1
    for (int i = 0; i < 80; i++) begin
      a = {21'd0, 6'(($urandom % 3) * 16), 5'd0} | {26'd0, 1'(i % 2), 5'd0}
          | {27'd0, 3'($urandom % 8), 2'(0)};
      if ($urandom % 2) req(a, 1'b1, 4'($urandom_range(1, 15)), $urandom, lat);
      else              req(a, 1'b0, 4'h0, 32'h0, lat);
    end

    repeat (5) @(negedge clk);
    check32("pending_expectations", 32'(exp_q.size()), 32'd0);
    check32("rd_wr_overlap", 32'(overlap), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_cache_ctrl.md
Name: wb_cache_ctrl

Overview:
Direct-mapped, write-back, write-allocate data cache controller between one upstream port (ufp, 32-bit words) and the downstream line memory (dfp, 256-bit lines). It holds tag, valid and dirty state and line storage in flops. It places upstream word writes into 32-byte lines and sequences hit, writeback and allocate through a Moore FSM.

Parameters:
SETS, 16, number of lines; power of two, ≥2; IDX_W = log2(SETS), TAG_W = 27 - IDX_W

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
ufp_addr  input  32  byte address; [4:0] offset, [4+IDX_W:5] index, [31:5+IDX_W] tag; [1:0] ignored
ufp_rmask  input  4  nonzero = read request
ufp_wmask  input  4  nonzero = write request, byte enables
ufp_wdata  input  32  write word
ufp_rdata  output  32  read word, valid when ufp_resp=1
ufp_resp  output  1  one-cycle completion pulse
dfp_addr  output  32  line address, [4:0]=0
dfp_read  output  1  line read request, held until dfp_resp
dfp_write  output  1  line write request, held until dfp_resp
dfp_wdata  output  256  victim line
dfp_rdata  input  256  fill line, valid with dfp_resp
dfp_resp  input  1  downstream completion pulse

Behaviour:
- Upstream contract: rmask and wmask are never both nonzero. The requester holds all ufp_* inputs stable from request until the ufp_resp cycle, and may issue a new request the cycle after ufp_resp.
- Reset: state=IDLE; all valid=0, dirty=0; ufp_resp=0, ufp_rdata=0, dfp_read=0, dfp_write=0, dfp_addr=0, dfp_wdata=0. Line data and tags are not reset.
- Reset mid-operation abandons the request with no ufp_resp. dfp_read and dfp_write are 0 from the cycle after the rst edge. A late dfp_resp is ignored.
- FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE.
  - IDLE: a request (rmask|wmask ≠ 0) latches addr, masks and wdata, then → COMPARE.
  - COMPARE: hit = valid[idx] && tag[idx]==req tag.
    - Read hit: ufp_rdata = line word at offset[4:2]; ufp_resp=1; → IDLE.
    - Write hit: bytes with wmask=1 replace the matching line bytes; all other bytes are unchanged. dirty=1; ufp_resp=1; → IDLE.
    - Miss with valid && dirty: → WRITEBACK.
    - Otherwise: → ALLOCATE.
  - WRITEBACK: dfp_write=1, dfp_addr={old tag, idx, 5'b0}, dfp_wdata=stored line. On dfp_resp → ALLOCATE.
  - ALLOCATE: dfp_read=1, dfp_addr={req tag, idx, 5'b0}. On dfp_resp: line=dfp_rdata, tag=req tag, valid=1, dirty=0, → COMPARE. The re-compare hits, so a write miss merges one cycle after the fill.
- dfp_read and dfp_write are decoded from state (Moore). They are never high together. Both are 0 in IDLE and COMPARE.
- dfp_resp in IDLE or COMPARE is ignored.
- Latency from request cycle to ufp_resp:
  - hit: 2 cycles
  - clean miss: 3 cycles + dfp read latency
  - dirty miss: adds the writeback latency plus 1 cycle
- ufp_resp is high only in COMPARE-hit cycles. ufp_rdata holds its last value otherwise; it is 0 on writes.

Decomposition:
- Package cache_pkg holds:
  - state enum (IDLE, COMPARE, WRITEBACK, ALLOCATE)
  - LINE_W=256, OFFSET_W=5, WORD_W=32
  - the tag/index extraction functions
- Sub-module line_word_merge (combinational) takes the old line, word, offset and wmask, and returns the merged 256-bit line. The byte mask expands to 32 line byte-enables, shifted by offset[4:2]*4.

Test Plan:
1. Reset, then read 0x0000_0040 → ALLOCATE with dfp_addr=0x40, dfp_read=1. Return dfp_rdata with word1=0xDEADBEEF, read 0x44 → ufp_rdata=0xDEADBEEF, resp 2 cycles after the request.
2. Write 0x44, wdata=0x11223344, wmask=4'b0101 → hit, no dfp activity. Then read 0x44 → 0xDE22BE44.
3. Read 0x0000_0240 (same index, new tag, victim dirty) → dfp_write=1, dfp_addr=0x40, dfp_wdata word1=0xDE22BE44. Then dfp_read with dfp_addr=0x240; no overlap of read and write.
4. Write miss to 0x1C (clean, invalid), wmask=4'b1111 → allocate, then merge into word7 only. Verify the other words equal the fill data and dirty=1 via a later eviction.
5. Assert rst while in ALLOCATE → dfp_read=0 next cycle, no ufp_resp. A following read of the previously cached 0x40 misses.
6. Back-to-back hits on alternating sets 0 and 1 with a random dfp_resp delay of 0–5 cycles → scoreboard matches reference memory, with exactly one ufp_resp per request.
